crp16_alu_sequencer: RTL and testbench
======================================

// Module: crp16_alu_sequencer
// PURPOSE
//  Issue side of the CRP16 ALU: accepts operation requests over valid/ready, drives
//  the combinational ALU's x/y/select, captures result and v/c/n/z flags, and returns
//  a response over valid/ready. Adds a multi-cycle 16x16->16 MUL built from 16 ALU
//  add passes (shift-add). Holds the architectural flag register read by branch logic.
// PARAMETERS
//  WIDTH       16       datapath width; must match the ALU (only 16 is supported)
//  MUL_STEPS   16       shift-add iterations for MUL; must equal WIDTH
//  FLAG_RST    4'b0000  reset value of {v,c,n,z}
// PORTS
//  clock       in   1      rising-edge clock
//  resetn      in   1      asynchronous active-low reset
//  req_valid   in   1      request present
//  req_ready   out  1      sequencer can accept (1 only in IDLE)
//  req_op      in   4      ALU select code; ignored when req_mul=1
//  req_mul     in   1      1 = multi-cycle MUL
//  req_setf    in   1      1 = update flag register on completion
//  req_x       in   16     operand x / multiplicand
//  req_y       in   16     operand y / multiplier
//  rsp_valid   out  1      result available
//  rsp_ready   in   1      consumer takes result
//  rsp_data    out  16     result (MUL: low 16 bits of product)
//  flag_v/c/n/z out 1 each architectural flags
//  alu_x, alu_y out 16 each  ALU operands
//  alu_select  out  4      ALU select
//  alu_out     in   16     ALU result
//  alu_v/c/n/z in   1 each  ALU flags
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0,
//    flags=FLAG_RST, alu_x/alu_y=0, alu_select=0, step counter=0. Reset mid-op discards it.
//  - States: IDLE -> EXEC (req_mul=0) | MUL (req_mul=1); EXEC -> DONE; MUL -> DONE after
//    MUL_STEPS cycles; DONE -> IDLE when rsp_ready=1.
//  - Accept when req_valid&req_ready at edge T: latch op/mul/setf/x/y.
//  - EXEC (cycle T+1): alu_x=x, alu_y=y, alu_select=op; at edge capture rsp_data=alu_out,
//    flags. rsp_valid=1 from T+2. Single-op latency 2 cycles accept->valid.
//  - MUL: acc=0, mc=x, mp=y at accept. Each step: alu_select=4'b1000, alu_x=acc,
//    alu_y=mc & {16{mp[0]}}; edge: acc<=alu_out, mc<=mc<<1, mp<=mp>>1, cnt++.
//    After step 15 (T+16) rsp_data<=alu_out; rsp_valid from T+17. No early exit.
//  - MUL flags: z=(product[15:0]==0), v=c=n=0. ALU overflow/carry mid-MUL ignored;
//    product wraps mod 2^16.
//  - Flag register updates only at the edge entering DONE and only if setf latched;
//    otherwise flags hold. Flags never change in IDLE/EXEC/MUL/DONE otherwise.
//  - DONE: rsp_valid=1, rsp_data stable until rsp_ready sampled 1; then IDLE next cycle.
//    req_ready=0 in DONE; no same-cycle accept on response handshake (1 idle cycle).
//  - req_valid without req_ready is ignored; inputs outside accept edge are don't-care.
//  - alu_* outputs hold last driven values in IDLE/DONE (no glitch requirement).
// STRUCTURE
//  - Shared header crp16_alu_defs.vh: ALU select encodings (SEL_SLL 4'b0000,
//    SEL_ADD 4'b1000, SEL_SUB 4'b1010, SEL_SLTU 4'b1100, SEL_SLT 4'b1110, ...),
//    state encodings (IDLE/EXEC/MUL/DONE), flag bit order {v,c,n,z}.
//  - One sub-module: crp16_flag_reg (4-bit async-reset register with load enable).
//  - ALU is external; instantiated alongside by the integrating datapath.
// TESTING (bench pairs sequencer with crp16_alu)
//  - ADD 0x7FFF+0x0001, setf=1 -> rsp_data 0x8000 at T+2, v=1 c=0 n=1 z=0.
//  - SUB 0x0005-0x0005, setf=0 after prior ADD -> rsp_data 0x0000, flags unchanged.
//  - MUL 0x0123*0x0045, setf=1 -> rsp_data 0x4E6F at T+17, z=0 v=c=n=0; req_ready=0 T+1..T+17.
//  - MUL 0x0100*0x0100 -> rsp_data 0x0000, z=1 (wrap); rsp_ready held 0 for 5 cycles
//    -> rsp_valid/rsp_data stable, then IDLE one cycle after handshake.
//  - resetn pulsed low at step 8 of MUL -> rsp_valid=0, req_ready=1, flags=FLAG_RST immediately.
//  - Back-to-back: SLT 0xFFFF,0x0001 then SLTU same -> 0x0001 then 0x0000, one idle gap.

Source files
------------

// File: rtl/crp16_alu_sequencer_pkg.sv
// Shared definitions for the CRP16 ALU sequencer: ALU select codes, FSM states,
// flag bit positions and the shift-add partial-product helper.
package crp16_alu_sequencer_pkg;

    localparam int CRP16_W = 16;

    localparam logic [3:0] SEL_SLL  = 4'b0000;
    localparam logic [3:0] SEL_ADD  = 4'b1000;
    localparam logic [3:0] SEL_SUB  = 4'b1010;
    localparam logic [3:0] SEL_SLTU = 4'b1100;
    localparam logic [3:0] SEL_SLT  = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Flag vector order is {v,c,n,z}
    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    function automatic logic [CRP16_W-1:0] mul_addend(input logic [CRP16_W-1:0] mc,
                                                      input logic               mp_bit);
        return mc & {CRP16_W{mp_bit}};
    endfunction

endpackage

// File: rtl/crp16_alu_sequencer_flag_reg.sv
// Architectural {v,c,n,z} flag register: async active-low reset to RST_VAL,
// loads only when load is asserted.
module crp16_flag_reg #(
    parameter logic [3:0] RST_VAL = 4'b0000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       load,
    input  logic [3:0] flags_in,
    output logic [3:0] flags
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;

    always_comb begin
        flags_d = flags_q;
        if (load) begin
            flags_d = flags_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            flags_q <= RST_VAL;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

endmodule

// File: rtl/crp16_alu_sequencer.sv
// CRP16 ALU issue sequencer: valid/ready request in, drives the external ALU,
// captures result/flags, returns a response; MUL is 16 shift-add ALU passes.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// EXEC  | single ALU pass, result captured at the end of the cycle
// MUL   | shift-add step cnt_q, ALU adds the next partial product
// DONE  | rsp_valid=1, result held until rsp_ready
module crp16_alu_sequencer
    import crp16_alu_sequencer_pkg::*;
#(
    parameter int         WIDTH     = 16,
    parameter int         MUL_STEPS = 16,
    parameter logic [3:0] FLAG_RST  = 4'b0000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic             req_mul,
    input  logic             req_setf,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             flag_v,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_z,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [3:0]       alu_select,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_v,
    input  logic             alu_c,
    input  logic             alu_n,
    input  logic             alu_z
);

    localparam int                CNT_W    = $clog2(MUL_STEPS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MUL_STEPS - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   alu_x_q, alu_x_d;
    logic [WIDTH-1:0]   alu_y_q, alu_y_d;
    logic [3:0]         alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0]   mc_q, mc_d;
    logic [WIDTH-1:0]   mp_q, mp_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mul_q, mul_d;
    logic               setf_q, setf_d;

    logic               accept;
    logic               last_step;
    logic               flag_load;
    logic [3:0]         flag_next;
    logic [3:0]         flags;

    assign accept    = req_valid && (state_q == ST_IDLE);
    assign last_step = (state_q == ST_MUL) && (cnt_q == CNT_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            alu_sel_q  <= '0;
            mc_q       <= '0;
            mp_q       <= '0;
            rsp_data_q <= '0;
            cnt_q      <= '0;
            mul_q      <= 1'b0;
            setf_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_x_q    <= alu_x_d;
            alu_y_q    <= alu_y_d;
            alu_sel_q  <= alu_sel_d;
            mc_q       <= mc_d;
            mp_q       <= mp_d;
            rsp_data_q <= rsp_data_d;
            cnt_q      <= cnt_d;
            mul_q      <= mul_d;
            setf_q     <= setf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = req_mul ? ST_MUL : ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
            ST_MUL:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_DONE);
    end

    // mc_q/mp_q run one step ahead of the ALU operands so the next addend is ready at each edge
    always_comb begin
        alu_x_d    = alu_x_q;
        alu_y_d    = alu_y_q;
        alu_sel_d  = alu_sel_q;
        mc_d       = mc_q;
        mp_d       = mp_q;
        rsp_data_d = rsp_data_q;
        cnt_d      = cnt_q;
        mul_d      = mul_q;
        setf_d     = setf_q;
        if (accept) begin
            mul_d  = req_mul;
            setf_d = req_setf;
            cnt_d  = '0;
            mc_d   = req_x << 1;
            mp_d   = req_y >> 1;
            if (req_mul) begin
                alu_x_d   = '0;
                alu_y_d   = mul_addend(req_x, req_y[0]);
                alu_sel_d = SEL_ADD;
            end else begin
                alu_x_d   = req_x;
                alu_y_d   = req_y;
                alu_sel_d = req_op;
            end
        end else if (state_q == ST_EXEC) begin
            rsp_data_d = alu_out;
        end else if (state_q == ST_MUL) begin
            alu_x_d = alu_out;
            alu_y_d = mul_addend(mc_q, mp_q[0]);
            mc_d    = mc_q << 1;
            mp_d    = mp_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (last_step) begin
                rsp_data_d = alu_out;
            end
        end
    end

    // MUL reports only zero; ALU carry/overflow from intermediate adds is meaningless
    always_comb begin
        flag_load = setf_q && ((state_q == ST_EXEC) || last_step);
        if (mul_q) begin
            flag_next = {3'b000, (alu_out == '0)};
        end else begin
            flag_next = {alu_v, alu_c, alu_n, alu_z};
        end
    end

    crp16_flag_reg #(
        .RST_VAL (FLAG_RST)
    ) u_flag_reg (
        .clock    (clock),
        .resetn   (resetn),
        .load     (flag_load),
        .flags_in (flag_next),
        .flags    (flags)
    );

    assign flag_v     = flags[FLAG_V];
    assign flag_c     = flags[FLAG_C];
    assign flag_n     = flags[FLAG_N];
    assign flag_z     = flags[FLAG_Z];
    assign rsp_data   = rsp_data_q;
    assign alu_x      = alu_x_q;
    assign alu_y      = alu_y_q;
    assign alu_select = alu_sel_q;

endmodule

// File: tb/tb_crp16_alu_sequencer.sv
// Self-checking bench for crp16_alu_sequencer paired with a behavioural CRP16 ALU;
// expected responses go into a scoreboard queue at issue and are popped on response.
module tb_crp16_alu_sequencer;
    import crp16_alu_sequencer_pkg::*;

    logic        clock;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic        req_mul;
    logic        req_setf;
    logic [15:0] req_x;
    logic [15:0] req_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        flag_v, flag_c, flag_n, flag_z;
    logic [15:0] alu_x, alu_y, alu_out;
    logic [3:0]  alu_select;
    logic        alu_v, alu_c, alu_n, alu_z;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  flags;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    crp16_alu_sequencer #(
        .WIDTH     (16),
        .MUL_STEPS (16),
        .FLAG_RST  (4'b0000)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_mul    (req_mul),
        .req_setf   (req_setf),
        .req_x      (req_x),
        .req_y      (req_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .flag_v     (flag_v),
        .flag_c     (flag_c),
        .flag_n     (flag_n),
        .flag_z     (flag_z),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_select (alu_select),
        .alu_out    (alu_out),
        .alu_v      (alu_v),
        .alu_c      (alu_c),
        .alu_n      (alu_n),
        .alu_z      (alu_z)
    );

    // Behavioural ALU: returns {v,c,n,z,result}
    function automatic logic [19:0] alu_model(input logic [3:0] sel,
                                              input logic [15:0] x,
                                              input logic [15:0] y);
        logic [16:0] s;
        logic [15:0] r;
        logic        v, c;
        s = '0; r = '0; v = 1'b0; c = 1'b0;
        case (sel)
            SEL_ADD: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[15:0];
                c = s[16];
                v = (x[15] == y[15]) && (r[15] != x[15]);
            end
            SEL_SUB: begin
                r = x - y;
                c = (x < y);
                v = (x[15] != y[15]) && (r[15] != x[15]);
            end
            SEL_SLTU: r = {15'b0, (x < y)};
            SEL_SLT:  r = {15'b0, ($signed(x) < $signed(y))};
            SEL_SLL:  r = x << y[3:0];
            default:  r = '0;
        endcase
        return {v, c, r[15], (r == 16'h0000), r};
    endfunction

    always_comb begin
        {alu_v, alu_c, alu_n, alu_z, alu_out} = alu_model(alu_select, alu_x, alu_y);
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] data, input logic [3:0] flags);
        exp_t e;
        e.data  = data;
        e.flags = flags;
        sb.push_back(e);
    endtask

    // Returns at the negedge following the accepting edge
    task automatic issue(input logic [3:0] op, input logic mul, input logic setf,
                         input logic [15:0] x, input logic [15:0] y);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_mul   = mul;
        req_setf  = setf;
        req_x     = x;
        req_y     = y;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
        @(negedge clock);
        req_valid = 1'b0;
        req_x     = 16'($urandom);
        req_y     = 16'($urandom);
        req_op    = 4'($urandom);
    endtask

    // Cycles spent busy before rsp_valid; busy_ok reports req_ready stayed low
    task automatic wait_rsp(output int gap, output logic busy_ok);
        gap     = 0;
        busy_ok = 1'b1;
        while (!rsp_valid && gap < 100) begin
            if (req_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clock);
            gap++;
        end
        if (req_ready !== 1'b0) busy_ok = 1'b0;
        if (gap >= 100) check("rsp_timeout", 32'(gap), 32'd0);
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"}, 32'(rsp_data), 32'(e.data));
            check({tag, "_flags"}, 32'({flag_v, flag_c, flag_n, flag_z}), 32'(e.flags));
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int          gap;
        logic        busy_ok;
        logic        stable;
        logic [15:0] rx, ry;
        logic [19:0] m;

        resetn    = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'h0;
        req_mul   = 1'b0;
        req_setf  = 1'b0;
        req_x     = 16'h0;
        req_y     = 16'h0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clock);

        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_flags", 32'({flag_v, flag_c, flag_n, flag_z}), 32'h0);
        check("rst_alu_ops", 32'({alu_x, alu_y, alu_select} == 36'h0), 32'd1);
        resetn = 1'b1;
        @(negedge clock);

        // ADD overflow into sign bit, flags updated
        push_exp(16'h8000, 4'b1010);
        issue(SEL_ADD, 1'b0, 1'b1, 16'h7FFF, 16'h0001);
        check("add_alu_select", 32'(alu_select), 32'(SEL_ADD));
        wait_rsp(gap, busy_ok);
        check("add_latency", 32'(gap), 32'd1);
        check_rsp("add");
        handshake();

        // SUB without setf leaves ADD flags in place
        push_exp(16'h0000, 4'b1010);
        issue(SEL_SUB, 1'b0, 1'b0, 16'h0005, 16'h0005);
        wait_rsp(gap, busy_ok);
        check_rsp("sub_nosetf");
        handshake();

        // MUL 0x0123*0x0045
        push_exp(16'h4E6F, 4'b0000);
        issue(SEL_SLL, 1'b1, 1'b1, 16'h0123, 16'h0045);
        wait_rsp(gap, busy_ok);
        check("mul_latency", 32'(gap), 32'd16);
        check("mul_busy_ready", 32'(busy_ok), 32'd1);
        check_rsp("mul");
        handshake();

        // MUL wrap to zero, response stalled 5 cycles
        push_exp(16'h0000, 4'b0001);
        issue(SEL_SUB, 1'b1, 1'b1, 16'h0100, 16'h0100);
        wait_rsp(gap, busy_ok);
        stable = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h0000 || req_ready !== 1'b0) stable = 1'b0;
        end
        check("mul_wrap_stall_stable", 32'(stable), 32'd1);
        check_rsp("mul_wrap");
        handshake();
        check("post_hs_idle", 32'({req_ready, rsp_valid}), 32'b10);

        // Reset mid-MUL at step 8 discards the op and restores flags
        issue(SEL_ADD, 1'b1, 1'b1, 16'h0123, 16'h0045);
        repeat (8) @(negedge clock);
        resetn = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_flags", 32'({flag_v, flag_c, flag_n, flag_z}), 32'h0);
        check("midrst_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Back-to-back SLT then SLTU with one idle gap
        push_exp(16'h0001, 4'b0000);
        issue(SEL_SLT, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
        wait_rsp(gap, busy_ok);
        check_rsp("slt");
        push_exp(16'h0000, 4'b0000);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = SEL_SLTU;
        req_mul   = 1'b0;
        req_setf  = 1'b0;
        req_x     = 16'hFFFF;
        req_y     = 16'h0001;
        check("b2b_no_accept_in_done", 32'(req_ready), 32'd0);
        @(negedge clock);
        rsp_ready = 1'b0;
        check("b2b_idle_gap", 32'({req_ready, rsp_valid}), 32'b10);
        @(negedge clock);
        req_valid = 1'b0;
        wait_rsp(gap, busy_ok);
        check("sltu_latency", 32'(gap), 32'd1);
        check_rsp("sltu");
        handshake();

        // Random MUL / ADD with flag updates
        for (int i = 0; i < 6; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            if (i % 2 == 0) begin
                push_exp(16'(rx * ry), {3'b000, (16'(rx * ry) == 16'h0000)});
                issue(SEL_ADD, 1'b1, 1'b1, rx, ry);
            end else begin
                m = alu_model(SEL_ADD, rx, ry);
                push_exp(m[15:0], m[19:16]);
                issue(SEL_ADD, 1'b0, 1'b1, rx, ry);
            end
            wait_rsp(gap, busy_ok);
            check_rsp("rand");
            handshake();
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
